short_stack_unit: RTL and testbench
===================================

# short_stack_unit

Per-ray short traversal stack that sits directly downstream of the list unit's miss port (`list_to_ss`) and upstream of traversal. The block does four things:
- Pushes far-child entries sent by traversal.
- On a leaf miss, pops the ray's top entry and restarts traversal from it.
- When the stack is empty, either restarts the ray from the root (after an overflow) or reports a final miss to the shader.
- Uses the list unit's hit reports to clear a finished ray's stack.

## Interface
Parameters:
- DEPTH, 4, stack entries per ray (power of 2, 2..8)
- NUM_RAYS, 512, ray slots; equals 2**$bits(rayID_t)

Ports:
- clk  input  1  clock; every register is rising-edge
- rst  input  1  asynchronous, active-low reset
- trav_to_ss_valid  input  1  push request
- trav_to_ss_data  input  trav_to_ss_t  {rayID, nodeID, t_max}
- trav_to_ss_stall  output  1  always 0 (a push completes in one cycle)
- list_to_ss_valid  input  1  leaf-miss pop request
- list_to_ss_data  input  list_to_ss_t  {ray_info, t_max_leaf}
- list_to_ss_stall  output  1  pop back-pressure
- hit_clear_valid  input  1  ray terminated by a hit (driven from list_to_rs accept)
- hit_clear_rayID  input  rayID_t  ray to clear
- ss_to_trav_valid  output  1  restart request
- ss_to_trav_data  output  ss_to_trav_t  {ray_info, nodeID, t_min, t_max}
- ss_to_trav_stall  input  1
- ss_to_shade_valid  output  1  final miss
- ss_to_shade_data  output  ss_to_shade_t  {ray_info}
- ss_to_shade_stall  input  1

## Operation
- **Per-ray state.** Register arrays indexed by rayID:
  - ptr[$clog2(DEPTH)]: next write slot
  - cnt[$clog2(DEPTH)+1]
  - ovf[1]
- **Entry storage.** Entries {nodeID, t_max} live in a simple dual-port BRAM with NUM_RAYS*DEPTH words at address {rayID, slot}. The write port serves pushes; the read port serves pops.
- **Push** (valid): write at {rayID, ptr}; then ptr <= ptr+1 (wraps mod DEPTH).
  - If cnt < DEPTH: cnt <= cnt+1.
  - Else: cnt is unchanged and ovf <= 1 (the oldest entry is overwritten).
- **Pop accept** = list_to_ss_valid & ~list_to_ss_stall. Three cases:
  - **cnt > 0:** read {rayID, ptr-1}; then ptr <= ptr-1 and cnt <= cnt-1. Result: RESTART_ENTRY, emitted on ss_to_trav with nodeID = entry.nodeID, t_min = t_max_leaf, t_max = entry.t_max.
  - **cnt == 0 & ovf:** no BRAM read; ovf <= 0. Result: RESTART_ROOT, emitted on ss_to_trav with nodeID = 0, t_min = t_max_leaf, t_max = 32'h7F80_0000 (+inf).
  - **cnt == 0 & ~ovf:** no BRAM read. Result: MISS, emitted on ss_to_shade. ptr is left as is.
- **Hit clear** (valid): cnt <= 0, ovf <= 0.
- **Ray ownership.** A ray is only ever at one point in the pipeline, so push, pop and clear in the same cycle always target distinct rayIDs. All three update the register arrays in parallel. Same-rayID collisions are an assertion error under `ifndef SYNTH` and their behaviour is undefined.
- **Output routing.** The pop result carries a 2-bit kind tag {ENTRY, ROOT, MISS} and is demultiplexed at the output. The pipe stalls only on the stall of the selected port. Result order is preserved across both ports.

## Timing
- **Pop latency:** an accepted pop presents its output valid 2 cycles later (BRAM read, then output register). Same for all three kinds.
- **Throughput:** 1 pop/cycle while the selected output is unstalled.
- **Back-pressure:** list_to_ss_stall is asserted when the pop pipe (2 stages plus 2-entry skid) has no room for the in-flight stages. It may be asserted while list_to_ss_valid is 0. Upstream holds its data while stalled.
- **Push:** takes effect at the clock edge. A pop of the same ray accepted in the next cycle sees the pushed entry (the BRAM is write-first, or the read is bypassed from the write register).
- **Reset (rst = 0, async):**
  - all cnt, ptr and ovf = 0;
  - pipe emptied;
  - ss_to_trav_valid = 0, ss_to_shade_valid = 0, list_to_ss_stall = 0, trav_to_ss_stall = 0.
  - BRAM contents are don't-care.
  - Reset mid-operation discards in-flight pops.
- **Output data hold:** data stays stable while valid & stall.

## Structure
- Shared package:
  - typedefs trav_to_ss_t, ss_to_trav_t, ss_to_shade_t, nodeID_t;
  - constant ROOT_NODE = 0;
  - constant FLOAT_POS_INF = 32'h7F80_0000.
  - rayID_t, ray_info_t, float_t and list_to_ss_t are existing package types.
- Sub-modules:
  - pop pipeline: existing pipe_valid_stall (DEPTH 2) with existing fifo (DEPTH 2) as the output skid;
  - entry memory: one BRAM wrapper, bram_dual_rw_{NUM_RAYS*DEPTH}x{entry width}.

## Test plan
- Push 3 entries for ray 5 (nodes 10, 11, 12 with t_max 1.0, 2.0, 3.0), then pop with t_max_leaf = 0.5 → ss_to_trav {node 12, t_min 0.5, t_max 3.0} 2 cycles after accept; two further pops return 11, then 10; a fourth pop → ss_to_shade miss for ray 5.
- Push 6 entries (nodes 1..6) to ray 7 with DEPTH = 4 → pops return 6, 5, 4, 3; the next pop → RESTART_ROOT {node 0, t_min = t_max_leaf, t_max = +inf}; the pop after that → MISS.
- Push 2 entries to ray 9, hit_clear ray 9, pop ray 9 → MISS, with no ss_to_trav output.
- Back-to-back pops for rays 1..8 with ss_to_trav_stall held high for 10 cycles → list_to_ss_stall rises within 4 accepts; no result is lost or reordered after the stall releases.
- Same cycle: push to ray 3, pop of ray 4, clear of ray 6 → all three state updates are observed independently and correctly.
- Assert rst mid-stream with 2 pops in flight → both valids drop immediately; a post-reset pop of any ray → MISS.

Source files
------------

// File: rtl/short_stack_unit_pkg.sv
// Shared types and constants for the per-ray short traversal stack.
// Contents: ray/node/float scalar types, the interface structs exchanged with
// the list unit, traversal and the shader, the stored stack entry, and the
// pop-result tag that steers each result to traversal or to the shader.
package short_stack_unit_pkg;

    typedef logic [8:0]  rayID_t;
    typedef logic [15:0] nodeID_t;
    typedef logic [31:0] float_t;

    typedef struct packed {
        rayID_t      rayID;
        logic [15:0] pixel;
    } ray_info_t;

    typedef struct packed {
        ray_info_t ray_info;
        float_t    t_max_leaf;
    } list_to_ss_t;

    typedef struct packed {
        rayID_t  rayID;
        nodeID_t nodeID;
        float_t  t_max;
    } trav_to_ss_t;

    typedef struct packed {
        ray_info_t ray_info;
        nodeID_t   nodeID;
        float_t    t_min;
        float_t    t_max;
    } ss_to_trav_t;

    typedef struct packed {
        ray_info_t ray_info;
    } ss_to_shade_t;

    typedef struct packed {
        nodeID_t nodeID;
        float_t  t_max;
    } ss_entry_t;

    typedef enum logic [1:0] {
        PopEntry = 2'd0,
        PopRoot  = 2'd1,
        PopMiss  = 2'd2
    } pop_kind_t;

    typedef struct packed {
        pop_kind_t   kind;
        ss_to_trav_t trav;
    } pop_result_t;

    localparam nodeID_t ROOT_NODE     = '0;
    localparam float_t  FLOAT_POS_INF = 32'h7F80_0000;

endpackage

// File: rtl/short_stack_unit_fifo.sv
// Small shift-register FIFO used as the output register plus skid of the pop
// pipe. Entry 0 is the head and is driven straight from a register, so output
// data is stable while the consumer stalls.
// Ports: clk/rst (async active-low), push/push_data, pop, head, count.
// The owner guarantees no push when full and no pop when empty.
module short_stack_unit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d, wr_idx;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // A simultaneous pop shifts everything down one slot first.
        wr_idx = pop ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_q[i] <= mem_q[i+1];
            end
        end
        if (push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    assign head  = mem_q[0];
    assign count = count_q;

endmodule

// File: rtl/short_stack_unit.sv
// Per-ray short traversal stack between the list unit's miss port and
// traversal. Traversal pushes far-child entries; a leaf miss pops the ray's
// newest entry and restarts traversal from it, restarts from the root after an
// overflow, or reports a final miss to the shader. Hit reports clear a ray.
// Ports:
//   clk, rst                      clock, async active-low reset
//   trav_to_ss_*                  push request (never stalled)
//   list_to_ss_*                  leaf-miss pop request with back-pressure
//   hit_clear_valid/rayID         clear a ray finished by a hit
//   ss_to_trav_*                  restart request (entry or root)
//   ss_to_shade_*                 final miss
module short_stack_unit
    import short_stack_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NUM_RAYS = 512
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         trav_to_ss_valid,
    input  trav_to_ss_t  trav_to_ss_data,
    output logic         trav_to_ss_stall,
    input  logic         list_to_ss_valid,
    input  list_to_ss_t  list_to_ss_data,
    output logic         list_to_ss_stall,
    input  logic         hit_clear_valid,
    input  rayID_t       hit_clear_rayID,
    output logic         ss_to_trav_valid,
    output ss_to_trav_t  ss_to_trav_data,
    input  logic         ss_to_trav_stall,
    output logic         ss_to_shade_valid,
    output ss_to_shade_t ss_to_shade_data,
    input  logic         ss_to_shade_stall
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned CW       = PW + 1;
    localparam int unsigned AW       = $bits(rayID_t) + PW;
    localparam int unsigned OutDepth = 3;
    localparam int unsigned OCW      = $clog2(OutDepth + 1);

    logic [PW-1:0]       ptr_q [NUM_RAYS];
    logic [CW-1:0]       cnt_q [NUM_RAYS];
    logic [NUM_RAYS-1:0] ovf_q;
    ss_entry_t           mem [NUM_RAYS*DEPTH];

    rayID_t        push_ray, pop_ray;
    logic [PW-1:0] push_ptr, pop_ptr_dec;
    logic [CW-1:0] push_cnt, pop_cnt;
    logic          pop_acc;
    pop_kind_t     pop_kind;
    ss_entry_t     push_entry;

    assign trav_to_ss_stall = 1'b0;

    assign push_ray          = trav_to_ss_data.rayID;
    assign push_ptr          = ptr_q[push_ray];
    assign push_cnt          = cnt_q[push_ray];
    assign push_entry.nodeID = trav_to_ss_data.nodeID;
    assign push_entry.t_max  = trav_to_ss_data.t_max;

    assign pop_ray     = list_to_ss_data.ray_info.rayID;
    assign pop_cnt     = cnt_q[pop_ray];
    assign pop_ptr_dec = ptr_q[pop_ray] - 1'b1;
    assign pop_acc     = list_to_ss_valid && !list_to_ss_stall;

    always_comb begin
        if (pop_cnt != '0) begin
            pop_kind = PopEntry;
        end else if (ovf_q[pop_ray]) begin
            pop_kind = PopRoot;
        end else begin
            pop_kind = PopMiss;
        end
    end

    // Push, pop and clear always target distinct rays, so they update the
    // arrays independently in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_RAYS); i++) begin
                ptr_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            if (trav_to_ss_valid) begin
                ptr_q[push_ray] <= push_ptr + 1'b1;
                if (push_cnt == CW'(DEPTH)) begin
                    ovf_q[push_ray] <= 1'b1;
                end else begin
                    cnt_q[push_ray] <= push_cnt + 1'b1;
                end
            end
            if (pop_acc) begin
                if (pop_kind == PopEntry) begin
                    ptr_q[pop_ray] <= pop_ptr_dec;
                    cnt_q[pop_ray] <= pop_cnt - 1'b1;
                end else if (pop_kind == PopRoot) begin
                    ovf_q[pop_ray] <= 1'b0;
                end
            end
            if (hit_clear_valid) begin
                cnt_q[hit_clear_rayID] <= '0;
                ovf_q[hit_clear_rayID] <= 1'b0;
            end
        end
    end

    // Entry BRAM: write port for pushes, registered read port for pops.
    ss_entry_t rd_q;
    logic [AW-1:0] wr_addr, rd_addr;
    assign wr_addr = {push_ray, push_ptr};
    assign rd_addr = {pop_ray, pop_ptr_dec};

    always_ff @(posedge clk) begin
        if (trav_to_ss_valid) begin
            mem[wr_addr] <= push_entry;
        end
        if (pop_acc && pop_kind == PopEntry) begin
            rd_q <= mem[rd_addr];
        end
    end

    // Stage 1 travels alongside the BRAM read and never stalls; the stall
    // below keeps enough room downstream for whatever is in flight.
    logic        s1_valid_q;
    pop_kind_t   s1_kind_q;
    ray_info_t   s1_info_q;
    float_t      s1_tmin_q;
    pop_result_t s1_result, head;
    logic [OCW-1:0] out_count;
    logic        out_pop, head_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= pop_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (pop_acc) begin
            s1_kind_q <= pop_kind;
            s1_info_q <= list_to_ss_data.ray_info;
            s1_tmin_q <= list_to_ss_data.t_max_leaf;
        end
    end

    always_comb begin
        s1_result.kind          = s1_kind_q;
        s1_result.trav.ray_info = s1_info_q;
        s1_result.trav.t_min    = s1_tmin_q;
        s1_result.trav.nodeID   = ROOT_NODE;
        s1_result.trav.t_max    = FLOAT_POS_INF;
        if (s1_kind_q == PopEntry) begin
            s1_result.trav.nodeID = rd_q.nodeID;
            s1_result.trav.t_max  = rd_q.t_max;
        end
    end

    assign list_to_ss_stall = ({1'b0, out_count} + {{OCW{1'b0}}, s1_valid_q}) >= (OCW+1)'(OutDepth);

    short_stack_unit_fifo #(
        .WIDTH($bits(pop_result_t)),
        .DEPTH(OutDepth)
    ) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s1_valid_q),
        .push_data(s1_result),
        .pop      (out_pop),
        .head     (head),
        .count    (out_count)
    );

    assign head_valid                = out_count != '0;
    assign ss_to_trav_valid          = head_valid && head.kind != PopMiss;
    assign ss_to_shade_valid         = head_valid && head.kind == PopMiss;
    assign ss_to_trav_data           = head.trav;
    assign ss_to_shade_data.ray_info = head.trav.ray_info;
    assign out_pop = (ss_to_trav_valid && !ss_to_trav_stall) ||
                     (ss_to_shade_valid && !ss_to_shade_stall);

`ifndef SYNTH
    a_push_pop_distinct : assert property (@(posedge clk) disable iff (!rst)
        !(trav_to_ss_valid && pop_acc && push_ray == pop_ray))
        else $error("push and pop target the same ray");
    a_push_clear_distinct : assert property (@(posedge clk) disable iff (!rst)
        !(trav_to_ss_valid && hit_clear_valid && push_ray == hit_clear_rayID))
        else $error("push and clear target the same ray");
    a_pop_clear_distinct : assert property (@(posedge clk) disable iff (!rst)
        !(pop_acc && hit_clear_valid && pop_ray == hit_clear_rayID))
        else $error("pop and clear target the same ray");
`endif

endmodule

// File: tb/tb_short_stack_unit.sv
module tb_short_stack_unit;
    import short_stack_unit_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         trav_to_ss_valid;
    trav_to_ss_t  trav_to_ss_data;
    logic         trav_to_ss_stall;
    logic         list_to_ss_valid;
    list_to_ss_t  list_to_ss_data;
    logic         list_to_ss_stall;
    logic         hit_clear_valid;
    rayID_t       hit_clear_rayID;
    logic         ss_to_trav_valid;
    ss_to_trav_t  ss_to_trav_data;
    logic         ss_to_trav_stall;
    logic         ss_to_shade_valid;
    ss_to_shade_t ss_to_shade_data;
    logic         ss_to_shade_stall;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    short_stack_unit #(.DEPTH(4), .NUM_RAYS(512)) dut (
        .clk              (clk),
        .rst              (rst),
        .trav_to_ss_valid (trav_to_ss_valid),
        .trav_to_ss_data  (trav_to_ss_data),
        .trav_to_ss_stall (trav_to_ss_stall),
        .list_to_ss_valid (list_to_ss_valid),
        .list_to_ss_data  (list_to_ss_data),
        .list_to_ss_stall (list_to_ss_stall),
        .hit_clear_valid  (hit_clear_valid),
        .hit_clear_rayID  (hit_clear_rayID),
        .ss_to_trav_valid (ss_to_trav_valid),
        .ss_to_trav_data  (ss_to_trav_data),
        .ss_to_trav_stall (ss_to_trav_stall),
        .ss_to_shade_valid(ss_to_shade_valid),
        .ss_to_shade_data (ss_to_shade_data),
        .ss_to_shade_stall(ss_to_shade_stall)
    );

    function automatic ray_info_t info_of(input rayID_t r);
        ray_info_t ri;
        ri.rayID = r;
        ri.pixel = {7'h2A, r};
        return ri;
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic push(input rayID_t r, input nodeID_t n, input float_t t);
        trav_to_ss_data.rayID  = r;
        trav_to_ss_data.nodeID = n;
        trav_to_ss_data.t_max  = t;
        trav_to_ss_valid = 1'b1;
        @(negedge clk);
        trav_to_ss_valid = 1'b0;
    endtask

    // One pop; returns whether any output was valid one cycle after accept
    // and the outputs two cycles after accept.
    task automatic do_pop(input rayID_t r, input float_t tl, output logic early,
                          output logic tv, output logic sv, output ss_to_trav_t td,
                          output ss_to_shade_t sd);
        int guard;
        guard = 0;
        list_to_ss_data.ray_info   = info_of(r);
        list_to_ss_data.t_max_leaf = tl;
        list_to_ss_valid = 1'b1;
        while (list_to_ss_stall && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (guard >= 100) $display("FAIL pop_accept_timeout ray %0d: stall stuck 1, required 0", r);
        else passed++;
        @(negedge clk);
        list_to_ss_valid = 1'b0;
        early = ss_to_trav_valid | ss_to_shade_valid;
        @(negedge clk);
        tv = ss_to_trav_valid;
        sv = ss_to_shade_valid;
        td = ss_to_trav_data;
        sd = ss_to_shade_data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        trav_to_ss_valid = 1'b0;
        trav_to_ss_data = '0;
        list_to_ss_valid = 1'b0;
        list_to_ss_data = '0;
        hit_clear_valid = 1'b0;
        hit_clear_rayID = '0;
        ss_to_trav_stall = 1'b0;
        ss_to_shade_stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ss_to_trav_valid !== 1'b0) $display("FAIL reset_trav_valid: got %b, required 0", ss_to_trav_valid); else passed++;
        checks++; if (ss_to_shade_valid !== 1'b0) $display("FAIL reset_shade_valid: got %b, required 0", ss_to_shade_valid); else passed++;
        checks++; if (list_to_ss_stall !== 1'b0) $display("FAIL reset_list_stall: got %b, required 0", list_to_ss_stall); else passed++;
        checks++; if (trav_to_ss_stall !== 1'b0) $display("FAIL reset_trav_stall: got %b, required 0", trav_to_ss_stall); else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if ((ss_to_trav_valid | ss_to_shade_valid) !== 1'b0) $display("FAIL post_reset_valids: got 1, required 0"); else passed++;
    endtask

    task automatic test_lifo();
        logic early, tv, sv;
        ss_to_trav_t td;
        ss_to_shade_t sd;
        push(9'd5, 16'd10, 32'h3F80_0000);
        push(9'd5, 16'd11, 32'h4000_0000);
        push(9'd5, 16'd12, 32'h4040_0000);
        do_pop(9'd5, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (early !== 1'b0) $display("FAIL lifo_latency_early: got valid at 1 cycle, required 2"); else passed++;
        checks++; if (tv !== 1'b1 || sv !== 1'b0) $display("FAIL lifo_pop0_route: got trav %b shade %b, required 1 0", tv, sv); else passed++;
        checks++; if (td.nodeID !== 16'd12) $display("FAIL lifo_pop0_node: got %0d, required 12", td.nodeID); else passed++;
        checks++; if (td.t_min !== 32'h3F00_0000) $display("FAIL lifo_pop0_tmin: got %h, required 3f000000", td.t_min); else passed++;
        checks++; if (td.t_max !== 32'h4040_0000) $display("FAIL lifo_pop0_tmax: got %h, required 40400000", td.t_max); else passed++;
        checks++; if (td.ray_info !== info_of(9'd5)) $display("FAIL lifo_pop0_info: got %h, required %h", td.ray_info, info_of(9'd5)); else passed++;
        do_pop(9'd5, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (tv !== 1'b1 || td.nodeID !== 16'd11 || td.t_max !== 32'h4000_0000)
            $display("FAIL lifo_pop1: got v %b node %0d tmax %h, required 1 11 40000000", tv, td.nodeID, td.t_max); else passed++;
        do_pop(9'd5, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (tv !== 1'b1 || td.nodeID !== 16'd10 || td.t_max !== 32'h3F80_0000)
            $display("FAIL lifo_pop2: got v %b node %0d tmax %h, required 1 10 3f800000", tv, td.nodeID, td.t_max); else passed++;
        do_pop(9'd5, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL lifo_miss_route: got trav %b shade %b, required 0 1", tv, sv); else passed++;
        checks++; if (sd.ray_info !== info_of(9'd5)) $display("FAIL lifo_miss_info: got %h, required %h", sd.ray_info, info_of(9'd5)); else passed++;
    endtask

    task automatic test_overflow();
        logic early, tv, sv;
        ss_to_trav_t td;
        ss_to_shade_t sd;
        for (int i = 1; i <= 6; i++) push(9'd7, nodeID_t'(i), 32'h4100_0000 + i);
        for (int k = 0; k < 4; k++) begin
            do_pop(9'd7, 32'h3E80_0000, early, tv, sv, td, sd);
            checks++;
            if (tv !== 1'b1 || td.nodeID !== nodeID_t'(6 - k) || td.t_max !== 32'h4100_0000 + 6 - k)
                $display("FAIL ovf_pop%0d: got v %b node %0d tmax %h, required 1 %0d %h", k, tv, td.nodeID, td.t_max, 6 - k, 32'h4100_0000 + 6 - k);
            else passed++;
        end
        do_pop(9'd7, 32'h3E80_0000, early, tv, sv, td, sd);
        checks++; if (tv !== 1'b1 || sv !== 1'b0) $display("FAIL ovf_root_route: got trav %b shade %b, required 1 0", tv, sv); else passed++;
        checks++; if (td.nodeID !== 16'd0 || td.t_min !== 32'h3E80_0000 || td.t_max !== 32'h7F80_0000)
            $display("FAIL ovf_root_data: got node %0d tmin %h tmax %h, required 0 3e800000 7f800000", td.nodeID, td.t_min, td.t_max); else passed++;
        do_pop(9'd7, 32'h3E80_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL ovf_final_miss: got trav %b shade %b, required 0 1", tv, sv); else passed++;
    endtask

    task automatic test_clear();
        logic early, tv, sv;
        ss_to_trav_t td;
        ss_to_shade_t sd;
        push(9'd9, 16'd90, 32'h3F80_0000);
        push(9'd9, 16'd91, 32'h4000_0000);
        hit_clear_rayID = 9'd9;
        hit_clear_valid = 1'b1;
        @(negedge clk);
        hit_clear_valid = 1'b0;
        do_pop(9'd9, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL clear_miss: got trav %b shade %b, required 0 1", tv, sv); else passed++;
    endtask

    task automatic test_back_to_back();
        ss_to_trav_t got[$];
        int accepts, accepts_at_stall, hold_bad, shade_seen;
        logic stall_seen, prev_held;
        ss_to_trav_t prev_data;
        accepts = 0; accepts_at_stall = 0; hold_bad = 0; shade_seen = 0;
        stall_seen = 1'b0; prev_held = 1'b0; prev_data = '0;
        for (int r = 1; r <= 8; r++) push(rayID_t'(r), nodeID_t'(100 + r), 32'h4200_0000 + r);
        ss_to_trav_stall = 1'b1;
        fork
            begin
                for (int r = 1; r <= 8; r++) begin
                    int guard;
                    guard = 0;
                    list_to_ss_data.ray_info   = info_of(rayID_t'(r));
                    list_to_ss_data.t_max_leaf = 32'h3F00_0000;
                    list_to_ss_valid = 1'b1;
                    while (list_to_ss_stall && guard < 100) begin
                        if (!stall_seen) begin
                            stall_seen = 1'b1;
                            accepts_at_stall = accepts;
                        end
                        @(negedge clk);
                        guard++;
                    end
                    @(negedge clk);
                    accepts++;
                end
                list_to_ss_valid = 1'b0;
            end
            begin
                repeat (10) @(negedge clk);
                ss_to_trav_stall = 1'b0;
            end
            begin
                for (int c = 0; c < 150 && got.size() < 8; c++) begin
                    @(negedge clk);
                    #1;
                    if (ss_to_shade_valid) shade_seen++;
                    if (prev_held && ss_to_trav_valid && ss_to_trav_data !== prev_data) hold_bad++;
                    prev_held = ss_to_trav_valid && ss_to_trav_stall;
                    prev_data = ss_to_trav_data;
                    if (ss_to_trav_valid && !ss_to_trav_stall) got.push_back(ss_to_trav_data);
                end
            end
        join
        checks++; if (!stall_seen || accepts_at_stall > 4 || accepts_at_stall < 1)
            $display("FAIL b2b_stall_rise: seen %b after %0d accepts, required 1 within 4", stall_seen, accepts_at_stall); else passed++;
        checks++; if (hold_bad !== 0) $display("FAIL b2b_data_hold: got %0d changes while stalled, required 0", hold_bad); else passed++;
        checks++; if (shade_seen !== 0) $display("FAIL b2b_no_shade: got %0d shade cycles, required 0", shade_seen); else passed++;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= got.size())
                $display("FAIL b2b_order[%0d]: got nothing, required node %0d", i, 101 + i);
            else if (got[i].nodeID !== nodeID_t'(101 + i) || got[i].ray_info !== info_of(rayID_t'(i + 1)))
                $display("FAIL b2b_order[%0d]: got node %0d ray %0d, required node %0d ray %0d", i, got[i].nodeID, got[i].ray_info.rayID, 101 + i, i + 1);
            else passed++;
        end
    endtask

    task automatic test_same_cycle();
        logic early, tv, sv;
        ss_to_trav_t td;
        ss_to_shade_t sd;
        push(9'd4, 16'd40, 32'h4280_0000);
        push(9'd6, 16'd60, 32'h3F80_0000);
        push(9'd6, 16'd61, 32'h4000_0000);
        checks++; if (list_to_ss_stall !== 1'b0) $display("FAIL same_cycle_ready: got stall %b, required 0", list_to_ss_stall); else passed++;
        trav_to_ss_data.rayID  = 9'd3;
        trav_to_ss_data.nodeID = 16'd30;
        trav_to_ss_data.t_max  = 32'h4300_0000;
        trav_to_ss_valid = 1'b1;
        list_to_ss_data.ray_info   = info_of(9'd4);
        list_to_ss_data.t_max_leaf = 32'h3F00_0000;
        list_to_ss_valid = 1'b1;
        hit_clear_rayID = 9'd6;
        hit_clear_valid = 1'b1;
        @(negedge clk);
        trav_to_ss_valid = 1'b0;
        list_to_ss_valid = 1'b0;
        hit_clear_valid  = 1'b0;
        @(negedge clk);
        checks++; if (ss_to_trav_valid !== 1'b1 || ss_to_trav_data.nodeID !== 16'd40 || ss_to_trav_data.t_max !== 32'h4280_0000)
            $display("FAIL same_cycle_pop4: got v %b node %0d tmax %h, required 1 40 42800000", ss_to_trav_valid, ss_to_trav_data.nodeID, ss_to_trav_data.t_max); else passed++;
        do_pop(9'd3, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (tv !== 1'b1 || td.nodeID !== 16'd30 || td.t_max !== 32'h4300_0000)
            $display("FAIL same_cycle_push3: got v %b node %0d tmax %h, required 1 30 43000000", tv, td.nodeID, td.t_max); else passed++;
        do_pop(9'd3, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL same_cycle_ray3_empty: got trav %b shade %b, required 0 1", tv, sv); else passed++;
        do_pop(9'd4, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL same_cycle_ray4_empty: got trav %b shade %b, required 0 1", tv, sv); else passed++;
        do_pop(9'd6, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL same_cycle_ray6_cleared: got trav %b shade %b, required 0 1", tv, sv); else passed++;
    endtask

    task automatic test_reset_mid();
        logic early, tv, sv;
        ss_to_trav_t td;
        ss_to_shade_t sd;
        push(9'd2, 16'd20, 32'h3F80_0000);
        push(9'd2, 16'd21, 32'h4000_0000);
        list_to_ss_data.ray_info   = info_of(9'd2);
        list_to_ss_data.t_max_leaf = 32'h3F00_0000;
        list_to_ss_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        list_to_ss_valid = 1'b0;
        checks++; if (ss_to_trav_valid !== 1'b1) $display("FAIL rst_mid_inflight: got trav valid %b, required 1", ss_to_trav_valid); else passed++;
        rst = 1'b0;
        #1;
        checks++; if ((ss_to_trav_valid | ss_to_shade_valid) !== 1'b0)
            $display("FAIL rst_mid_valids: got trav %b shade %b, required 0 0", ss_to_trav_valid, ss_to_shade_valid); else passed++;
        checks++; if (list_to_ss_stall !== 1'b0) $display("FAIL rst_mid_stall: got %b, required 0", list_to_ss_stall); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_pop(9'd2, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (early !== 1'b0 || sv !== 1'b1 || tv !== 1'b0)
            $display("FAIL rst_mid_ray2_miss: got early %b trav %b shade %b, required 0 0 1", early, tv, sv); else passed++;
        do_pop(9'd100, 32'h3F00_0000, early, tv, sv, td, sd);
        checks++; if (sv !== 1'b1 || tv !== 1'b0) $display("FAIL rst_mid_ray100_miss: got trav %b shade %b, required 0 1", tv, sv); else passed++;
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_clear();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
